// File: rtl/fetch_predecode.sv
// Fetch predecoder: finds the first call/return per group, drives RAS push/pop and a redirect after the delay slot.
// One registered stage (accept N -> out_valid N+1); stalls upstream while the output is held or a redirect pulses.
module fetch_predecode #(
   parameter int FETCH_WIDTH = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [31:0]               in_pc,
   input  logic [32*FETCH_WIDTH-1:0] in_instr,
   input  logic [FETCH_WIDTH-1:0]    in_mask,
   input  logic [32:0]               ras_top,
   output logic                      ras_push_req,
   output logic                      ras_pop_req,
   output logic [31:0]               ras_push_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [31:0]               out_pc,
   output logic [32*FETCH_WIDTH-1:0] out_instr,
   output logic [FETCH_WIDTH-1:0]    out_mask,
   output logic                      redirect_valid,
   output logic [31:0]               redirect_pc
);

   localparam int KW = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
   localparam logic [FETCH_WIDTH-1:0] SLOT0 = FETCH_WIDTH'(1);

   typedef struct packed {
      logic        valid;
      logic [31:0] data;
   } ras_t;

   typedef enum logic {
      ST_RUN,
      ST_WAIT_DS
   } state_t;

   ras_t   ras;
   state_t state;

   logic [31:0]            saved_target;
   logic [FETCH_WIDTH-1:0] is_call;
   logic [FETCH_WIDTH-1:0] is_ret;
   logic [FETCH_WIDTH-1:0] is_jal;
   logic [31:0]            slot_pc4 [FETCH_WIDTH];
   logic [31:0]            jal_tgt  [FETCH_WIDTH];

   logic                   found;
   logic [KW-1:0]          k;
   logic                   ds_avail;
   logic [FETCH_WIDTH-1:0] keep_ds;
   logic [FETCH_WIDTH-1:0] keep_cf;
   logic                   cf_call;
   logic                   cf_redirect;
   logic [31:0]            cf_target;
   logic                   accept;
   logic                   decode_en;

   assign ras = ras_top;

   for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_dec
      logic [31:0] w;
      assign w           = in_instr[32*i +: 32];
      assign slot_pc4[i] = in_pc + 32'(4 * (i + 1));
      assign is_jal[i]   = (w[31:26] == 6'b000011);
      assign is_call[i]  = is_jal[i]
                         | ((w[31:26] == 6'b000000) && (w[5:0] == 6'b001001) && (w[15:11] != 5'd0))
                         | ((w[31:26] == 6'b000001) && (w[20:17] == 4'b1000));
      assign is_ret[i]   = (w[31:26] == 6'b000000) && (w[5:0] == 6'b001000) && (w[25:21] == 5'd31);
      assign jal_tgt[i]  = {slot_pc4[i][31:28], w[25:0], 2'b00};
   end

   // Descending scan so the lowest masked control-flow slot wins.
   always_comb begin
      found = 1'b0;
      k     = '0;
      for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
         if (in_mask[i] && (is_call[i] || is_ret[i])) begin
            found = 1'b1;
            k     = KW'(i);
         end
      end
   end

   always_comb begin
      ds_avail = 1'b0;
      keep_ds  = '0;
      keep_cf  = '0;
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         if (i == int'(k) + 1) ds_avail = in_mask[i];
         keep_ds[i] = (i <= int'(k) + 1);
         keep_cf[i] = (i <= int'(k));
      end
   end

   assign cf_call       = is_call[k];
   assign cf_redirect   = is_jal[k] || (!cf_call && ras.valid);
   assign cf_target     = is_jal[k] ? jal_tgt[k] : ras.data;
   assign ras_push_data = slot_pc4[k] + 32'd4;

   assign in_ready  = (!out_valid || out_ready) && !redirect_valid && !flush;
   assign accept    = in_valid && in_ready && !reset;
   assign decode_en = accept && (state == ST_RUN) && found;

   // Return target is taken from ras_top in the same cycle as the pop, i.e. before it lands.
   assign ras_push_req = decode_en && cf_call;
   assign ras_pop_req  = decode_en && !cf_call;

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= ST_RUN;
         out_valid      <= 1'b0;
         out_pc         <= '0;
         out_instr      <= '0;
         out_mask       <= '0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         saved_target   <= '0;
      end else begin
         redirect_valid <= 1'b0;
         if (flush) begin
            out_valid <= 1'b0;
            state     <= ST_RUN;
         end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (accept) begin
               out_valid <= 1'b1;
               out_pc    <= in_pc;
               out_instr <= in_instr;
               if (state == ST_WAIT_DS) begin
                  out_mask       <= in_mask & SLOT0;
                  redirect_valid <= 1'b1;
                  redirect_pc    <= saved_target;
                  state          <= ST_RUN;
               end else if (found && cf_redirect) begin
                  if (ds_avail) begin
                     out_mask       <= in_mask & keep_ds;
                     redirect_valid <= 1'b1;
                     redirect_pc    <= cf_target;
                  end else begin
                     // Delay slot lives in the next group; redirect once it arrives.
                     out_mask     <= in_mask & keep_cf;
                     saved_target <= cf_target;
                     state        <= ST_WAIT_DS;
                  end
               end else begin
                  out_mask <= in_mask;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_fetch_predecode.sv
// Randomized scoreboard bench for fetch_predecode against a slot-level reference model.
module tb_fetch_predecode;

   logic        clk = 1'b0;
   logic        reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic        in_ready, ras_push_req, ras_pop_req, out_valid, redirect_valid;
   logic [31:0] in_pc = '0, ras_push_data, out_pc, redirect_pc;
   logic [63:0] in_instr = '0, out_instr;
   logic [1:0]  in_mask = '0, out_mask;
   logic [32:0] ras_top = '0;

   always #5 clk = ~clk;

   fetch_predecode #(.FETCH_WIDTH(2)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr), .in_mask(in_mask),
      .ras_top(ras_top), .ras_push_req(ras_push_req), .ras_pop_req(ras_pop_req), .ras_push_data(ras_push_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr), .out_mask(out_mask),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   typedef struct {
      bit          rst;
      bit          in_ready, push, pop, out_valid, redir;
      logic [31:0] pdata, rpc;
   } cyc_t;

   typedef struct {
      logic [31:0] pc;
      logic [63:0] instr;
      logic [1:0]  mask;
   } grp_t;

   typedef enum int {K_NONE, K_JAL, K_CALL, K_RET} kind_e;

   cyc_t cyc_q[$];
   grp_t grp_q[$];
   int   n_chk = 0, n_fail = 0;

   bit          m_ov = 0, m_redir = 0, m_wait = 0, kill_prev = 0;
   logic [31:0] m_rpc = '0, m_tgt = '0, m_ds_pc = '0;

   localparam logic [31:0] NOP = 32'h0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] enc_jal(input logic [25:0] t);
      return {6'd3, t};
   endfunction
   function automatic logic [31:0] enc_jalr(input logic [4:0] rs, input logic [4:0] rd);
      return {6'd0, rs, 5'd0, rd, 5'd0, 6'd9};
   endfunction
   function automatic logic [31:0] enc_jr(input logic [4:0] rs);
      return {6'd0, rs, 15'd0, 6'd8};
   endfunction
   function automatic logic [31:0] enc_regimm(input logic [4:0] rt);
      return {6'd1, 5'd4, rt, 16'h0010};
   endfunction

   function automatic kind_e classify(input logic [31:0] w);
      if (w[31:26] == 6'd3) return K_JAL;
      if (w[31:26] == 6'd0 && w[5:0] == 6'd9 && w[15:11] != 5'd0) return K_CALL;
      if (w[31:26] == 6'd1 && (w[20:16] == 5'd16 || w[20:16] == 5'd17)) return K_CALL;
      if (w[31:26] == 6'd0 && w[5:0] == 6'd8 && w[25:21] == 5'd31) return K_RET;
      return K_NONE;
   endfunction

   function automatic logic [31:0] rnd_instr();
      case ($urandom_range(0, 8))
         0: return enc_jal(26'($urandom));
         1: return enc_jalr(5'($urandom), ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom));
         2: return enc_regimm(5'd16);
         3: return enc_regimm(5'd17);
         4: return enc_regimm(5'd0);
         5: return enc_jr(5'd31);
         6: return enc_jr(5'($urandom));
         7: return NOP;
         default: return $urandom;
      endcase
   endfunction

   // One cycle of stimulus; the model predicts this cycle's outputs and the state after the next edge.
   task automatic step(input bit rst_i, input bit fl, input bit vld, input logic [31:0] pc,
                       input logic [31:0] i0, input logic [31:0] i1, input logic [1:0] msk,
                       input bit ordy, input bit rv, input logic [31:0] rd);
      cyc_t        e;
      grp_t        g;
      bit          acc, n_redir, redir;
      int          k;
      kind_e       kd;
      logic [31:0] sl [2];
      logic [31:0] cfpc, tgt, n_rpc;
      @(posedge clk);
      #2;
      if (kill_prev) grp_q.delete();
      reset = rst_i; flush = fl; in_valid = vld; in_pc = pc; in_instr = {i1, i0};
      in_mask = msk; out_ready = ordy; ras_top = {rv, rd};
      e.rst = rst_i;
      e.in_ready = (!m_ov || ordy) && !m_redir && !fl;
      e.out_valid = m_ov; e.redir = m_redir; e.rpc = m_rpc;
      e.push = 0; e.pop = 0; e.pdata = '0;
      acc = vld && e.in_ready && !rst_i;
      n_redir = 0; n_rpc = '0;
      if (acc) begin
         g.pc = pc; g.instr = {i1, i0}; g.mask = msk;
         if (m_wait) begin
            g.mask = msk & 2'b01;
            n_redir = 1; n_rpc = m_tgt; m_wait = 0;
         end else begin
            sl[0] = i0; sl[1] = i1; k = -1; kd = K_NONE;
            for (int s = 0; s < 2; s++)
               if (k < 0 && msk[s] && classify(sl[s]) != K_NONE) begin
                  k = s; kd = classify(sl[s]);
               end
            if (k >= 0) begin
               cfpc = pc + 32'(4 * k);
               if (kd == K_RET) e.pop = 1;
               else begin e.push = 1; e.pdata = cfpc + 32'd8; end
               redir = (kd == K_JAL) || (kd == K_RET && rv);
               tgt = rd;
               if (kd == K_JAL) tgt = {cfpc[31:28] + 4'((cfpc[27:0] + 28'd4) >> 28), sl[k][25:0], 2'b00};
               if (redir) begin
                  if (k == 0 && msk[1]) begin
                     n_redir = 1; n_rpc = tgt;
                  end else begin
                     g.mask = (k == 0) ? 2'b01 : 2'b11;
                     m_wait = 1; m_tgt = tgt; m_ds_pc = cfpc + 32'd4;
                  end
               end
            end
         end
         grp_q.push_back(g);
      end
      cyc_q.push_back(e);
      if (rst_i || fl) begin
         m_ov = 0; m_redir = 0; m_wait = 0;
      end else begin
         if (m_ov && ordy) m_ov = 0;
         if (acc) m_ov = 1;
         m_redir = n_redir;
         if (n_redir) m_rpc = n_rpc;
      end
      kill_prev = rst_i || fl;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, NOP, NOP, 2'b11, 1, 0, 32'h0);
   endtask

   // Monitor: compares each cycle's outputs and each output handshake against the queues.
   initial begin
      cyc_t e;
      grp_t g;
      forever begin
         @(negedge clk);
         if (cyc_q.size() != 0) begin
            e = cyc_q.pop_front();
            chk("ras_push_req", 64'(ras_push_req), 64'(e.push));
            chk("ras_pop_req", 64'(ras_pop_req), 64'(e.pop));
            if (e.push) chk("ras_push_data", 64'(ras_push_data), 64'(e.pdata));
            if (!e.rst) begin
               chk("in_ready", 64'(in_ready), 64'(e.in_ready));
               chk("out_valid", 64'(out_valid), 64'(e.out_valid));
               chk("redirect_valid", 64'(redirect_valid), 64'(e.redir));
               if (e.redir) chk("redirect_pc", 64'(redirect_pc), 64'(e.rpc));
               if (out_valid && out_ready) begin
                  if (grp_q.size() == 0) begin
                     n_chk++; n_fail++;
                     $display("FAIL out_group: got unexpected group pc=%h, expected none", out_pc);
                  end else begin
                     g = grp_q.pop_front();
                     chk("out_pc", 64'(out_pc), 64'(g.pc));
                     chk("out_instr", out_instr, g.instr);
                     chk("out_mask", 64'(out_mask), 64'(g.mask));
                  end
               end
            end
         end
      end
   end

   initial begin
      repeat (3) step(1, 0, 0, 32'h0, NOP, NOP, 2'b11, 1, 0, 32'h0);
      idle(1);
      chk("reset_out_pc", 64'(out_pc), 64'h0);
      chk("reset_out_instr", out_instr, 64'h0);
      chk("reset_out_mask", 64'(out_mask), 64'h0);
      chk("reset_redirect_pc", 64'(redirect_pc), 64'h0);

      // JAL in slot 0 with delay slot in the same group.
      step(0, 0, 1, 32'h1000, enc_jal(26'h0040000), NOP, 2'b11, 1, 0, 32'h0);
      idle(3);
      // JAL in slot 1: delay slot arrives in the following group.
      step(0, 0, 1, 32'h2000, NOP, enc_jal(26'h0123456), 2'b11, 1, 0, 32'h0);
      idle(1);
      step(0, 0, 1, 32'h2008, NOP, NOP, 2'b11, 1, 0, 32'h0);
      idle(3);
      // Returns with and without a valid RAS top.
      step(0, 0, 1, 32'h3000, enc_jr(5'd31), NOP, 2'b11, 1, 1, 32'h1008);
      idle(3);
      step(0, 0, 1, 32'h3000, enc_jr(5'd31), NOP, 2'b11, 1, 0, 32'h1008);
      idle(2);
      // Output held under backpressure; upstream keeps offering a call group.
      step(0, 0, 1, 32'h4000, enc_jalr(5'd4, 5'd31), NOP, 2'b11, 0, 0, 32'h0);
      repeat (3) step(0, 0, 1, 32'h4100, enc_jalr(5'd4, 5'd31), NOP, 2'b11, 0, 0, 32'h0);
      step(0, 0, 0, 32'h0, NOP, NOP, 2'b11, 1, 0, 32'h0);
      idle(2);
      // Flush in WAIT_DS, then flush coincident with a JAL group.
      step(0, 0, 1, 32'h5000, NOP, enc_jal(26'h0000100), 2'b11, 1, 0, 32'h0);
      step(0, 1, 0, 32'h0, NOP, NOP, 2'b11, 1, 0, 32'h0);
      step(0, 0, 1, 32'h5008, NOP, NOP, 2'b11, 1, 0, 32'h0);
      idle(2);
      step(0, 1, 1, 32'h5100, enc_jal(26'h0000200), NOP, 2'b11, 1, 0, 32'h0);
      idle(3);
      // JALR then JAL: only slot 0 counts, no redirect.
      step(0, 0, 1, 32'h6000, enc_jalr(5'd2, 5'd31), enc_jal(26'h0000300), 2'b11, 1, 0, 32'h0);
      idle(3);

      for (int c = 0; c < 3000; c++) begin
         logic [31:0] pc;
         pc = m_wait ? m_ds_pc : ($urandom & 32'hFFFF_FFFC);
         step($urandom_range(0, 399) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0, pc,
              rnd_instr(), rnd_instr(), ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b01,
              $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, $urandom & 32'hFFFF_FFFC);
      end
      idle(4);
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
